cdc_reset_sequencer: RTL and testbench

CDC_RESET_SEQUENCER -- requirements
Module: cdc_reset_sequencer

---
 rtl/cdc_pkg.sv | 24 ++
 rtl/cdc_bit_synchronizer.sv | 27 ++
 rtl/cdc_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cdc_reset_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the reset sequencer.
package cdc_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StHold,
    StRelease,
    StRun
  } rst_seq_state_e;

  localparam int unsigned DefaultNumOut         = 3;
  localparam int unsigned DefaultHoldCycles     = 1024;
  localparam int unsigned DefaultStaggerCycles  = 16;
  localparam int unsigned DefaultDebounceCycles = 65536;

  // Largest of three values; sizes the shared counter width.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module cdc_bit_synchronizer (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_d, sync_q;

  // Shift the raw input through two flops.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/cdc_reset_sequencer.sv
// Sequenced reset generator: waits for PLL lock and a debounced external reset release,
// holds all resets, then releases the outputs one at a time in ascending order.
module cdc_reset_sequencer
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_OUT         = DefaultNumOut,
  parameter int unsigned HOLD_CYCLES     = DefaultHoldCycles,
  parameter int unsigned STAGGER_CYCLES  = DefaultStaggerCycles,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_locked_i,
  input  logic               ext_rst_ni,
  input  logic               sw_rst_req_i,
  output logic [NUM_OUT-1:0] rst_no,
  output logic               ready_o,
  output logic [7:0]         reset_count_o
);

  localparam int unsigned CntW =
      $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES)) + 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  logic pll_sync, ext_sync;

  cdc_bit_synchronizer u_sync_pll (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (pll_sync)
  );

  cdc_bit_synchronizer u_sync_ext (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ext_rst_ni),
    .q_o   (ext_sync)
  );

  logic [CntW-1:0]    deb_cnt_d, deb_cnt_q;
  logic               ext_ok_d, ext_ok_q;
  rst_seq_state_e     state_d, state_q;
  logic [CntW-1:0]    hold_cnt_d, hold_cnt_q;
  logic [CntW-1:0]    stag_cnt_d, stag_cnt_q;
  logic [NUM_OUT-1:0] rst_d, rst_q;
  logic [7:0]         cnt_d, cnt_q;
  logic               fault;

  // Debounce: ext_ok needs an unbroken run of synchronized highs; any low drops it at once.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    ext_ok_d  = ext_ok_q;
    if (!ext_sync) begin
      deb_cnt_d = '0;
      ext_ok_d  = 1'b0;
    end else if (!ext_ok_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_cnt_d = '0;
        ext_ok_d  = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + CntOne;
      end
    end
  end

  assign fault = !pll_sync || !ext_ok_q;

  // Sequencer next state and reset outputs; fault wins over a software request.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    rst_d      = rst_q;
    case (state_q)
      StAssert: begin
        rst_d      = '0;
        hold_cnt_d = '0;
        if (!fault) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (fault) begin
          state_d = StAssert;
          rst_d   = '0;
        end else if (sw_rst_req_i) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StRelease;
          stag_cnt_d = '0;
          rst_d      = NUM_OUT'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end
      end
      StRelease: begin
        if (fault || sw_rst_req_i) begin
          state_d = StAssert;
          rst_d   = '0;
        end else if (&rst_q) begin
          state_d = StRun;
        end else if (stag_cnt_q == StagLast) begin
          stag_cnt_d = '0;
          // Release the next higher bit; lower bits stay released.
          rst_d      = (rst_q << 1) | NUM_OUT'(1);
        end else begin
          stag_cnt_d = stag_cnt_q + CntOne;
        end
      end
      StRun: begin
        if (fault || sw_rst_req_i) begin
          state_d = StAssert;
          rst_d   = '0;
        end
      end
      default: begin
        state_d = StAssert;
        rst_d   = '0;
      end
    endcase
  end

  // Saturating count of entries into ASSERT from any other state.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != StAssert) && (state_d == StAssert) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_cnt_q  <= '0;
      ext_ok_q   <= 1'b0;
      state_q    <= StAssert;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      rst_q      <= '0;
      cnt_q      <= 8'd0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      ext_ok_q   <= ext_ok_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      rst_q      <= rst_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rst_no        = rst_q;
  assign ready_o       = (state_q == StRun);
  assign reset_count_o = cnt_q;

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Bench for cdc_reset_sequencer: a time-since-hold-entry model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdc_reset_sequencer;

  localparam int unsigned NumOut   = 3;
  localparam int unsigned Hold     = 8;
  localparam int unsigned Stagger  = 4;
  localparam int unsigned Debounce = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pll = 1'b1;
  logic              ext = 1'b1;
  logic              sw  = 1'b0;
  logic [NumOut-1:0] rst_no;
  logic              ready;
  logic [7:0]        cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdc_reset_sequencer #(
    .NUM_OUT         (NumOut),
    .HOLD_CYCLES     (Hold),
    .STAGGER_CYCLES  (Stagger),
    .DEBOUNCE_CYCLES (Debounce)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pll_locked_i  (pll),
    .ext_rst_ni    (ext),
    .sw_rst_req_i  (sw),
    .rst_no        (rst_no),
    .ready_o       (ready),
    .reset_count_o (cnt)
  );

  // Model: inputs seen two edges late, ext healthy after Debounce straight highs,
  // outputs derived from time elapsed since the last hold entry.
  bit m_pll1 = 0, m_pll2 = 0, m_ext1 = 0, m_ext2 = 0;
  int m_run = 0;
  bit m_asserted = 1;
  int m_t = 0;
  int m_count = 0;
  bit m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pll1 = 0; m_pll2 = 0; m_ext1 = 0; m_ext2 = 0;
      m_run = 0; m_asserted = 1; m_t = 0; m_count = 0;
    end else begin
      m_fault = !m_pll2 || (m_run < Debounce);
      if (m_asserted) begin
        if (!m_fault) begin
          m_asserted = 0;
          m_t = 0;
        end
      end else if (m_fault || (sw && m_t >= Hold)) begin
        m_asserted = 1;
        if (m_count < 255) m_count++;
      end else if (sw) begin
        m_t = 0;
      end else if (m_t < 10000) begin
        m_t++;
      end
      m_run = m_ext2 ? ((m_run < Debounce) ? m_run + 1 : m_run) : 0;
      m_pll2 = m_pll1; m_pll1 = pll;
      m_ext2 = m_ext1; m_ext1 = ext;
    end
  end

  function automatic logic [NumOut-1:0] exp_rst();
    logic [NumOut-1:0] v;
    for (int k = 0; k < NumOut; k++) v[k] = !m_asserted && (m_t >= Hold + k * Stagger);
    return v;
  endfunction

  function automatic logic exp_ready();
    return !m_asserted && (m_t >= Hold + (NumOut - 1) * Stagger + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("model_rst_no", 32'(rst_no), 32'(exp_rst()));
    check("model_ready", 32'(ready), 32'(exp_ready()));
    check("model_count", 32'(cnt), 32'(m_count));
  end

  task automatic wait_rst(input logic [NumOut-1:0] v, input int maxc, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rst_no === v) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: rst_no is %b, never reached %b", name, rst_no, v);
    end
  endtask

  task automatic wait_ready(input int maxc, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: ready is %b, required 1 within %0d cycles", name, ready, maxc);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_rst_no", 32'(rst_no), 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_count", 32'(cnt), 32'h0);

    // Power-up: hold entry lands on edge 7 after release (2 sync + 4 debounce + 1).
    @(negedge clk) rst = 1'b0;
    repeat (14) @(posedge clk);
    #1 check("pwr_e14", 32'(rst_no), 32'b000);
    @(posedge clk); #1 check("pwr_e15", 32'(rst_no), 32'b001);
    repeat (3) @(posedge clk);
    #1 check("pwr_e18", 32'(rst_no), 32'b001);
    @(posedge clk); #1 check("pwr_e19", 32'(rst_no), 32'b011);
    repeat (4) @(posedge clk);
    #1 check("pwr_e23", 32'(rst_no), 32'b111);
    check("pwr_e23_ready", 32'(ready), 32'h0);
    @(posedge clk); #1 check("pwr_e24_ready", 32'(ready), 32'h1);

    // Lock loss in RUN: outputs drop on the third edge.
    @(negedge clk) pll = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("lock_e2", 32'(rst_no), 32'b111);
    @(posedge clk); #1 check("lock_e3", 32'(rst_no), 32'b000);
    check("lock_ready", 32'(ready), 32'h0);
    check("lock_count", 32'(cnt), 32'd1);
    @(negedge clk) pll = 1'b1;
    wait_ready(60, "relock_ready");

    // Bouncing external reset never qualifies; a request while asserted is ignored.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk) ext = 1'b0;
      if (r == 3) sw = 1'b1;
      @(negedge clk) begin ext = 1'b1; sw = 1'b0; end
      repeat (2) @(negedge clk);
    end
    @(negedge clk) ext = 1'b0;
    @(negedge clk);
    check("bounce_rst_no", 32'(rst_no), 32'b000);
    check("bounce_count", 32'(cnt), 32'd2);
    ext = 1'b1;
    wait_ready(60, "debounced_ready");

    // Software request in RUN, then again in RELEASE with only bit 0 out.
    @(negedge clk) sw = 1'b1;
    @(negedge clk) sw = 1'b0;
    wait_rst(3'b001, 60, "sw_release_bit0");
    @(negedge clk) sw = 1'b1;
    @(posedge clk); #1 check("sw_clear", 32'(rst_no), 32'b000);
    @(negedge clk) sw = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("sw_e8", 32'(rst_no), 32'b000);
    @(posedge clk); #1 check("sw_e9", 32'(rst_no), 32'b001);
    check("sw_count", 32'(cnt), 32'd4);

    // Software request during HOLD restarts the hold period without counting.
    @(negedge clk) sw = 1'b1;
    @(negedge clk) sw = 1'b0;
    repeat (4) @(negedge clk);
    sw = 1'b1;
    @(negedge clk) sw = 1'b0;
    check("sw_hold_count", 32'(cnt), 32'd5);

    // Asynchronous reset mid-release.
    wait_rst(3'b011, 60, "mid_release");
    #2 rst = 1'b1;
    #1 check("async_rst_no", 32'(rst_no), 32'b000);
    check("async_ready", 32'(ready), 32'h0);
    check("async_count", 32'(cnt), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_ready(60, "post_reset_ready");

    // Repeated lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) pll = 1'b0;
      repeat (4) @(negedge clk);
      pll = 1'b1;
      repeat (5) @(negedge clk);
    end
    wait_ready(60, "sat_ready");
    check("sat_count", 32'(cnt), 32'd255);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion by 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
